pe_ctrl_seq: RTL and testbench

PE_CTRL_SEQ -- requirements
Module: pe_ctrl_seq

---
 rtl/pe_ctrl_seq.sv | 155 +++++++++++++++
 tb/tb_pe_ctrl_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctrl_seq.sv
// PE control sequencer: runs one command through an L2 phase, an aggregation
// phase and a one-cycle done/hold state, driving the PE mux/add-sub configuration.
module pe_ctrl_seq #(
   parameter int unsigned L2_CYCLES  = 21,
   parameter int unsigned AGG_CYCLES = 37
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_cmd_valid,
   output logic       io_cmd_ready,
   input  logic       io_cmd_int,
   input  logic [2:0] io_cmd_rounding,
   input  logic       io_cmd_tininess,
   input  logic       io_abort,
   output logic [1:0] io_m_0_sel,
   output logic [1:0] io_m_1_sel,
   output logic [1:0] io_m_2_sel,
   output logic [1:0] io_m_3_sel,
   output logic [1:0] io_m_4_sel,
   output logic [1:0] io_m_5_sel,
   output logic [1:0] io_m_6_sel,
   output logic [1:0] io_m_7_sel,
   output logic [1:0] io_m_8_sel,
   output logic [1:0] io_m_9_sel,
   output logic [1:0] io_addsub_0_op,
   output logic [1:0] io_addsub_1_op,
   output logic       io_use_int,
   output logic [2:0] io_rounding,
   output logic       io_tininess,
   output logic       io_busy,
   output logic       io_done,
   output logic [1:0] io_phase
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_L2   = 2'd1,
      S_AGG  = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [7:0] L2_LOAD  = 8'(L2_CYCLES - 1);
   localparam logic [7:0] AGG_LOAD = 8'(AGG_CYCLES - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_use_int;
   logic [2:0] r_rounding;
   logic       r_tininess;

   state_t     w_state_nxt;
   logic [7:0] w_cnt_nxt;
   logic       w_accept;
   logic [1:0] w_m [10];
   logic [1:0] w_as;

   assign w_accept = io_cmd_valid && (r_state == S_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_use_int  <= 1'b0;
         r_rounding <= '0;
         r_tininess <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_use_int  <= io_cmd_int;
            r_rounding <= io_cmd_rounding;
            r_tininess <= io_cmd_tininess;
         end
      end
   end

   // Counter is reloaded only on phase entry and decremented only while nonzero.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (io_cmd_valid) begin
               w_state_nxt = S_L2;
               w_cnt_nxt   = L2_LOAD;
            end
         end
         S_L2: begin
            if (io_abort) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_AGG;
               w_cnt_nxt   = AGG_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_AGG: begin
            if (io_abort) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < 8; i++) w_m[i] = 2'b11;
      w_m[8] = 2'b10;
      w_m[9] = 2'b10;
      w_as   = 2'b00;
      case (r_state)
         S_L2: begin
            for (int unsigned i = 0; i < 4; i++) w_m[i] = 2'b01;
            for (int unsigned i = 4; i < 8; i++) w_m[i] = 2'b00;
            w_m[8] = 2'b01;
            w_m[9] = 2'b01;
            w_as   = 2'b01;
         end
         S_AGG: begin
            for (int unsigned i = 0; i < 4; i++) w_m[i] = 2'b01;
            for (int unsigned i = 4; i < 8; i++) w_m[i] = 2'b10;
            w_m[8] = 2'b00;
            w_m[9] = 2'b00;
         end
         default: ;
      endcase
   end

   assign io_m_0_sel     = w_m[0];
   assign io_m_1_sel     = w_m[1];
   assign io_m_2_sel     = w_m[2];
   assign io_m_3_sel     = w_m[3];
   assign io_m_4_sel     = w_m[4];
   assign io_m_5_sel     = w_m[5];
   assign io_m_6_sel     = w_m[6];
   assign io_m_7_sel     = w_m[7];
   assign io_m_8_sel     = w_m[8];
   assign io_m_9_sel     = w_m[9];
   assign io_addsub_0_op = w_as;
   assign io_addsub_1_op = w_as;

   assign io_use_int   = r_use_int;
   assign io_rounding  = r_rounding;
   assign io_tininess  = r_tininess;
   assign io_cmd_ready = (r_state == S_IDLE);
   assign io_busy      = (r_state != S_IDLE);
   assign io_done      = (r_state == S_HOLD);
   assign io_phase     = r_state;

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Directed bench for pe_ctrl_seq: default-length instance plus a 1/1-cycle instance.
module tb_pe_ctrl_seq;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic       valid, intm, tin, abort;
   logic [2:0] rnd;
   logic       ready, use_int, tin_o, busy, done;
   logic [2:0] rnd_o;
   logic [1:0] phase;
   logic [1:0] m0, m1, m2, m3, m4, m5, m6, m7, m8, m9, a0, a1;

   logic       valid2;
   logic       ready2, use_int2, tin_o2, busy2, done2;
   logic [2:0] rnd_o2;
   logic [1:0] phase2;
   logic [1:0] n0, n1, n2, n3, n4, n5, n6, n7, n8, n9, b0, b1;

   pe_ctrl_seq dut (
      .clock(clock), .reset(reset),
      .io_cmd_valid(valid), .io_cmd_ready(ready), .io_cmd_int(intm),
      .io_cmd_rounding(rnd), .io_cmd_tininess(tin), .io_abort(abort),
      .io_m_0_sel(m0), .io_m_1_sel(m1), .io_m_2_sel(m2), .io_m_3_sel(m3),
      .io_m_4_sel(m4), .io_m_5_sel(m5), .io_m_6_sel(m6), .io_m_7_sel(m7),
      .io_m_8_sel(m8), .io_m_9_sel(m9),
      .io_addsub_0_op(a0), .io_addsub_1_op(a1),
      .io_use_int(use_int), .io_rounding(rnd_o), .io_tininess(tin_o),
      .io_busy(busy), .io_done(done), .io_phase(phase)
   );

   pe_ctrl_seq #(.L2_CYCLES(1), .AGG_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset),
      .io_cmd_valid(valid2), .io_cmd_ready(ready2), .io_cmd_int(1'b0),
      .io_cmd_rounding(3'b010), .io_cmd_tininess(1'b0), .io_abort(1'b0),
      .io_m_0_sel(n0), .io_m_1_sel(n1), .io_m_2_sel(n2), .io_m_3_sel(n3),
      .io_m_4_sel(n4), .io_m_5_sel(n5), .io_m_6_sel(n6), .io_m_7_sel(n7),
      .io_m_8_sel(n8), .io_m_9_sel(n9),
      .io_addsub_0_op(b0), .io_addsub_1_op(b1),
      .io_use_int(use_int2), .io_rounding(rnd_o2), .io_tininess(tin_o2),
      .io_busy(busy2), .io_done(done2), .io_phase(phase2)
   );

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [23:0] SEL_L2   = 24'b01_01_01_01_00_00_00_00_01_01_01_01;
   localparam logic [23:0] SEL_AGG  = 24'b01_01_01_01_10_10_10_10_00_00_00_00;
   localparam logic [23:0] SEL_STOP = 24'b11_11_11_11_11_11_11_11_10_10_00_00;

   function automatic logic [23:0] exp_sel(input logic [1:0] ph);
      case (ph)
         2'd1:    return SEL_L2;
         2'd2:    return SEL_AGG;
         default: return SEL_STOP;
      endcase
   endfunction

   wire [23:0] sel_obs  = {m0, m1, m2, m3, m4, m5, m6, m7, m8, m9, a0, a1};
   wire [23:0] sel_obs2 = {n0, n1, n2, n3, n4, n5, n6, n7, n8, n9, b0, b1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_phase"}, 32'(phase), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_modes"}, 32'({use_int, rnd_o, tin_o}), 32'd0);
      chk({tag, "_sel"}, 32'(sel_obs), 32'(SEL_STOP));
   endtask

   logic [1:0] ph_exp;
   int         done_seen;

   initial begin
      reset = 1'b0; valid = 1'b0; intm = 1'b0; rnd = 3'b000; tin = 1'b0; abort = 1'b0;
      valid2 = 1'b0;
      #2;
      chk_reset_state("rst_init");
      chk("rst_init_dut1_phase", 32'(phase2), 32'd0);
      step();
      reset = 1'b1;

      // Full default-length command
      valid = 1'b1; intm = 1'b1; rnd = 3'b111; tin = 1'b1;
      for (int e = 0; e <= 58; e++) begin
         step();
         if (e == 0) valid = 1'b0;
         ph_exp = (e <= 20) ? 2'd1 : (e <= 57) ? 2'd2 : 2'd3;
         chk("run_phase", 32'(phase), 32'(ph_exp));
         chk("run_sel", 32'(sel_obs), 32'(exp_sel(ph_exp)));
         chk("run_done", 32'(done), (e == 58) ? 32'd1 : 32'd0);
         chk("run_busy", 32'(busy), 32'd1);
      end
      chk("run_modes", 32'({use_int, rnd_o, tin_o}), 32'b1_111_1);
      step();
      chk("run_end_phase", 32'(phase), 32'd0);
      chk("run_end_done", 32'(done), 32'd0);
      chk("run_end_sel", 32'(sel_obs), 32'(SEL_STOP));
      chk("run_end_modes", 32'({use_int, rnd_o, tin_o}), 32'b1_111_1);

      // Valid held high across a whole command: no second accept until IDLE
      valid = 1'b1; intm = 1'b0; rnd = 3'b011; tin = 1'b0;
      step();
      chk("hold_acc_phase", 32'(phase), 32'd1);
      chk("hold_acc_ready", 32'(ready), 32'd0);
      for (int k = 1; k <= 58; k++) begin
         step();
         chk("hold_ready", 32'(ready), 32'd0);
      end
      chk("hold_in_hold", 32'(phase), 32'd3);
      step();
      chk("hold_idle_phase", 32'(phase), 32'd0);
      chk("hold_idle_ready", 32'(ready), 32'd1);
      step();
      chk("hold_reaccept", 32'(phase), 32'd1);
      chk("hold_modes", 32'({use_int, rnd_o, tin_o}), 32'b0_011_0);
      valid = 1'b0; intm = 1'b1; rnd = 3'b110; tin = 1'b1;

      // Abort at AGG cycle 10
      for (int k = 0; k < 21; k++) step();
      chk("abort_in_agg", 32'(phase), 32'd2);
      for (int k = 0; k < 10; k++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_phase", 32'(phase), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_modes", 32'({use_int, rnd_o, tin_o}), 32'b0_011_0);
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (done) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
      chk("abort_still_idle", 32'(phase), 32'd0);

      // Valid with abort in IDLE is accepted
      valid = 1'b1; abort = 1'b1; intm = 1'b1; rnd = 3'b101; tin = 1'b1;
      step();
      valid = 1'b0; abort = 1'b0;
      chk("idle_abort_acc_phase", 32'(phase), 32'd1);
      chk("idle_abort_acc_modes", 32'({use_int, rnd_o, tin_o}), 32'b1_101_1);

      // Asynchronous reset at L2 cycle 5
      for (int k = 0; k < 5; k++) step();
      chk("pre_rst_phase", 32'(phase), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_state("rst_async");
      #1;
      reset = 1'b1;
      valid = 1'b1; intm = 1'b0; rnd = 3'b001; tin = 1'b1;
      step();
      valid = 1'b0;
      chk("post_rst_accept", 32'(phase), 32'd1);
      chk("post_rst_modes", 32'({use_int, rnd_o, tin_o}), 32'b0_001_1);

      // Abort during HOLD is ignored
      for (int k = 0; k < 58; k++) step();
      chk("hold_abort_phase", 32'(phase), 32'd3);
      chk("hold_abort_done", 32'(done), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("hold_abort_idle", 32'(phase), 32'd0);

      // One-cycle phases
      valid2 = 1'b1;
      step();
      valid2 = 1'b0;
      chk("short_p1", 32'(phase2), 32'd1);
      chk("short_sel1", 32'(sel_obs2), 32'(SEL_L2));
      chk("short_done1", 32'(done2), 32'd0);
      step();
      chk("short_p2", 32'(phase2), 32'd2);
      chk("short_sel2", 32'(sel_obs2), 32'(SEL_AGG));
      step();
      chk("short_p3", 32'(phase2), 32'd3);
      chk("short_done3", 32'(done2), 32'd1);
      chk("short_busy3", 32'(busy2), 32'd1);
      step();
      chk("short_p0", 32'(phase2), 32'd0);
      chk("short_done0", 32'(done2), 32'd0);
      chk("short_modes", 32'({use_int2, rnd_o2, tin_o2}), 32'b0_010_0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
